spart: RTL and testbench

- Special-purpose asynchronous receiver/transmitter (SPART) peripheral on the processor's 8-bit bidirectional I/O bus.
- Serialises bytes written by the bus master onto txd, and deserialises rxd into a receive buffer.
- Uses 8N1 framing: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Bit time is set by a 16-bit programmable divisor written over the bus; the companion driver block programs it from its br_cfg setting.

---
 rtl/spart.sv | 221 ++++++++++++++++++++++
 tb/tb_spart.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart.sv
// SPART: 8N1 serial transmitter/receiver on an 8-bit bidirectional I/O bus with a programmable divisor.
// Optional sticky overrun/framing-error status bits are enabled by defining SPART_STATUS_ERR_EN.
module spart #(
  parameter logic [15:0] DIV_RESET = 16'd2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [1:0] addr;
  } bus_req_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  bus_req_t   req;
  logic       rd_buf, wr_tx;
  logic [7:0] status, rx_buf;

  assign req    = '{rd: iocs & iorw, wr: iocs & ~iorw, addr: ioaddr};
  assign rd_buf = req.rd && (req.addr == 2'b00);
  assign wr_tx  = req.wr && (req.addr == 2'b00);

  assign databus = (req.rd && !req.addr[1]) ? (req.addr[0] ? status : rx_buf) : 8'hzz;

  // ---------------------------------------------------------------- divisor
  logic [15:0] div_q, div_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                div_q       <= DIV_RESET;
    else if (req.wr && req.addr == 2'b10)      div_q[7:0]  <= databus;
    else if (req.wr && req.addr == 2'b11)      div_q[15:8] <= databus;
  end

  // Each FSM snapshots this at frame start, so divisor writes never stretch a frame in flight.
  assign div_eff = (div_q < 16'd2) ? 16'd2 : div_q;

  // ---------------------------------------------------------------- transmit
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [7:0]  tx_sh, tx_sh_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        txd_n, tx_tick;

  assign tx_tick = (tx_cnt == tx_div - 16'd1);
  assign tbr     = (tx_state == TX_IDLE);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 16'd1;
    tx_div_n   = tx_div;
    tx_sh_n    = tx_sh;
    tx_bit_n   = tx_bit;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (wr_tx) begin
          tx_state_n = TX_START;
          tx_div_n   = div_eff;
          tx_sh_n    = databus;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_n = TX_DATA;
        tx_cnt_n   = '0;
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_tick) begin
        tx_cnt_n = '0;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        tx_bit_n = tx_bit + 3'd1;
        if (tx_bit == 3'd7) tx_state_n = TX_STOP;
      end
      TX_STOP: if (tx_tick) begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // txd is registered from the next state so the line never glitches
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_sh_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= DIV_RESET;
      tx_sh    <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_sh    <= tx_sh_n;
      tx_bit   <= tx_bit_n;
      txd      <= txd_n;
    end
  end

  // ---------------------------------------------------------------- receive
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [7:0]  rx_sh, rx_sh_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        rx_s1, rx_s2, rx_prev;
  logic        rx_tick, rx_half_tick, rx_done, rx_load;

  assign rx_tick      = (rx_cnt == rx_div - 16'd1);
  assign rx_half_tick = (rx_cnt == (rx_div >> 1) - 16'd1);
  assign rx_done      = (rx_state == RX_STOP) && rx_tick;
  assign rx_load      = rx_done && rx_s2;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 16'd1;
    rx_div_n   = rx_div;
    rx_sh_n    = rx_sh;
    rx_bit_n   = rx_bit;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        // a falling edge needs a high line first, which re-arms after a framing error
        if (rx_prev && !rx_s2) begin
          rx_state_n = RX_START;
          rx_div_n   = div_eff;
        end
      end
      RX_START: if (rx_half_tick) begin
        rx_cnt_n   = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_tick) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_bit_n = rx_bit + 3'd1;
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_cnt_n   = '0;
        rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= DIV_RESET;
      rx_sh    <= '0;
      rx_bit   <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_sh    <= rx_sh_n;
      rx_bit   <= rx_bit_n;
    end
  end

  // A load wins over a coincident buffer read, so the new byte is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_buf <= '0;
      rda    <= 1'b0;
    end else begin
      if (rx_load)     rx_buf <= rx_sh;
      if (rx_load)     rda    <= 1'b1;
      else if (rd_buf) rda    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- status
`ifdef SPART_STATUS_ERR_EN
  logic rd_stat, ovr_q, ferr_q;

  assign rd_stat = req.rd && (req.addr == 2'b01);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      if (rx_load && rda && !rd_buf) ovr_q  <= 1'b1;
      else if (rd_stat)              ovr_q  <= 1'b0;
      if (rx_done && !rx_s2)         ferr_q <= 1'b1;
      else if (rd_stat)              ferr_q <= 1'b0;
    end
  end

  assign status = {4'b0, ferr_q, ovr_q, tbr, rda};
`else
  assign status = {6'b0, tbr, rda};
`endif

endmodule

// File: tb/tb_spart.sv
// Bench for spart: directed steps with randomized bytes/divisors, checked against a frame-level model.
module tb_spart;
  localparam int DIV0 = 2604;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iocs = 1'b0;
  logic       iorw = 1'b1;
  logic [1:0] ioaddr = 2'b00;
  logic       drv_en = 1'b0;
  logic [7:0] drv_data = 8'h00;
  logic       rxd_drv = 1'b1;
  logic       loopback = 1'b0;
  wire  [7:0] databus;
  wire        rda, tbr, txd, rxd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  // behavioural receive-side model
  bit         m_rda = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_buf = 8'h00;

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd     = loopback ? txd : rxd_drv;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (databus[i]);
  end

  spart dut (
    .clk(clk), .rst_n(rst_n), .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr),
    .databus(databus), .rda(rda), .tbr(tbr), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_frame(input logic [7:0] b, input bit stop_ok);
    if (stop_ok) begin
      if (m_rda) m_ovr = 1'b1;
      m_rda = 1'b1;
      m_buf = b;
    end else m_ferr = 1'b1;
  endfunction

  function automatic logic [7:0] m_status();
`ifdef SPART_STATUS_ERR_EN
    return {4'b0, m_ferr, m_ovr, 1'b1, m_rda};
`else
    return {6'b0, 1'b1, m_rda};
`endif
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b0; ioaddr = a; drv_en = 1'b1; drv_data = d;
    @(negedge clk);
    iocs = 1'b0; iorw = 1'b1; drv_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_wr(2'b10, d[7:0]);
    bus_wr(2'b11, d[15:8]);
  endtask

  task automatic rd_buf_chk(input string tag);
    logic [7:0] d;
    bus_rd(2'b00, d);
    chk(tag, d, m_buf);
    m_rda = 1'b0;
    chk({tag, "_rda_clr"}, rda, m_rda);
  endtask

  task automatic rd_stat_chk(input string tag);
    logic [7:0] d;
    bus_rd(2'b01, d);
    chk(tag, d, m_status());
    m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic wait_rda(input int budget);
    int n = 0;
    while (!rda && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // drives one frame on rxd, starting at the current negedge
  task automatic rx_send(input logic [7:0] b, input int div, input bit stop);
    logic [9:0] fr = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_drv = fr[k];
      repeat (div) @(negedge clk);
    end
  endtask

  // writes a byte and checks every bit's first and last clock plus tbr timing
  task automatic tx_check(input logic [7:0] b, input int div, input bit inject);
    logic [9:0] fr = {1'b1, b, 1'b0};
    int n0;
    bus_wr(2'b00, b);
    n0 = cyc;
    chk("tx_tbr_busy", tbr, 1'b0);
    for (int k = 0; k < 10; k++) begin
      wait_until(n0 + k * div);
      chk($sformatf("tx_bit%0d_first", k), txd, fr[k]);
      if (inject && k == 3) bus_wr(2'b00, ~b);
      wait_until(n0 + (k + 1) * div - 1);
      chk($sformatf("tx_bit%0d_last", k), txd, fr[k]);
    end
    chk("tx_tbr_before_end", tbr, 1'b0);
    wait_until(n0 + 10 * div);
    chk("tx_tbr_after_end", tbr, 1'b1);
  endtask

  initial begin
    logic [7:0] d, b;
    int div, el, n0;
    bit ok;

    // reset
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_tbr", tbr, 1'b1);
    chk("rst_rda", rda, 1'b0);
    rst_n = 1'b1;
    rd_stat_chk("rst_status");
    @(negedge clk);
    #1 chk("bus_idle_z", databus, 8'hFF);
    @(negedge clk);
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b10;
    #1 chk("bus_rd_div_z", databus, 8'hFF);
    @(negedge clk);
    iocs = 1'b0;

    // full duplex at the reset divisor: receive A5 while transmitting 5A
    fork
      begin
        repeat (3 * DIV0) @(negedge clk);
        t_start = cyc;
        rx_send(8'hA5, DIV0, 1'b1);
      end
      begin
        wait_rda(40000);
        el = cyc - t_start;
        chk("rx_latency_ok", (el >= DIV0 * 19 / 2) && (el <= DIV0 * 19 / 2 + 8), 1'b1);
      end
      tx_check(8'h5A, DIV0, 1'b1);
    join
    m_frame(8'hA5, 1'b1);
    chk("rx_a5_rda", rda, m_rda);
    rd_buf_chk("rx_a5_data");

    // back-to-back receive
    set_div(16'h0010);
    fork
      begin
        rx_send(8'hE7, 16, 1'b1);
        rx_send(8'h24, 16, 1'b1);
      end
      begin
        wait_rda(400);
        m_frame(8'hE7, 1'b1);
        chk("b2b_rda1", rda, m_rda);
        rd_buf_chk("b2b_e7");
        wait_rda(400);
        m_frame(8'h24, 1'b1);
        chk("b2b_rda2", rda, m_rda);
        rd_buf_chk("b2b_24");
      end
    join

    // loopback at DIV=16
    loopback = 1'b1;
    tx_check(8'hC3, 16, 1'b0);
    wait_rda(100);
    m_frame(8'hC3, 1'b1);
    chk("loop_c3_rda", rda, m_rda);
    rd_buf_chk("loop_c3");

    // divisor below 2 behaves as 2
    for (int z = 0; z < 2; z++) begin
      b = 8'($urandom);
      set_div(16'(z));
      tx_check(b, 2, 1'b0);
      wait_rda(40);
      m_frame(b, 1'b1);
      rd_buf_chk($sformatf("loop_div%0d", z));
    end

    // randomized loopback
    for (int it = 0; it < 6; it++) begin
      div = $urandom_range(2, 40);
      b = 8'($urandom);
      set_div(16'(div));
      tx_check(b, div, 1'b0);
      wait_rda(4 * div + 10);
      m_frame(b, 1'b1);
      chk("rand_loop_rda", rda, m_rda);
      rd_buf_chk("rand_loop_data");
    end
    loopback = 1'b0;

    // randomized bench-driven receive, some frames with a bad stop bit
    for (int it = 0; it < 5; it++) begin
      div = $urandom_range(4, 40);
      b = 8'($urandom);
      ok = ($urandom_range(0, 2) != 0);
      set_div(16'(div));
      rx_send(b, div, ok);
      rxd_drv = 1'b1;
      repeat (div) @(negedge clk);
      m_frame(b, ok);
      chk("rand_rx_rda", rda, m_rda);
      rd_stat_chk("rand_rx_status");
      if (m_rda) rd_buf_chk("rand_rx_data");
    end

    // framing error then overrun
    set_div(16'h0010);
    rx_send(8'h3C, 16, 1'b0);
    rxd_drv = 1'b1;
    repeat (16) @(negedge clk);
    m_frame(8'h3C, 1'b0);
    chk("ferr_rda", rda, 1'b0);
    rd_stat_chk("ferr_status");
    rd_stat_chk("ferr_status_clr");
    rx_send(8'h11, 16, 1'b1);
    rx_send(8'h22, 16, 1'b1);
    repeat (4) @(negedge clk);
    m_frame(8'h11, 1'b1);
    m_frame(8'h22, 1'b1);
    chk("ovr_rda", rda, 1'b1);
    rd_stat_chk("ovr_status");
    rd_stat_chk("ovr_status_clr");
    rd_buf_chk("ovr_data");

    // asynchronous reset mid-frame, then divisor back at its reset value
    bus_wr(2'b00, 8'h00);
    repeat (20) @(negedge clk);
    chk("mid_txd_low", txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_txd", txd, 1'b1);
    chk("abort_tbr", tbr, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    m_rda = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    rd_stat_chk("abort_status");
    bus_wr(2'b00, 8'hFF);
    n0 = cyc;
    wait_until(n0 + 16);
    chk("div_rst_start_16", txd, 1'b0);
    wait_until(n0 + DIV0 - 1);
    chk("div_rst_start_end", txd, 1'b0);
    wait_until(n0 + DIV0);
    chk("div_rst_bit0", txd, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
